// File: rtl/shift_ctrl8.sv
// Command sequencer for the shifter8 datapath: loads the operand, then issues shift steps of at most 3.
// Optional build macro SHIFT_CTRL_SAT_EN clamps the accepted amount (8 for LSL/LSR, 7 for ASR) to cut latency.
module shift_ctrl8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_amt,
    input  logic [7:0] cmd_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic [2:0] sh_op,
    output logic [1:0] sh_shamt,
    output logic [7:0] sh_d_in,
    input  logic [7:0] sh_d_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LSL  = 3'b010;
    localparam logic [2:0] SH_LSR  = 3'b011;
    localparam logic [2:0] SH_ASR  = 3'b100;

    state_t     state_reg, state_next;
    logic [1:0] op_reg, op_next;
    logic [3:0] rem_reg, rem_next;
    logic [7:0] data_reg, data_next;

    logic [3:0] accept_rem;
    logic [1:0] step;
    logic [3:0] rem_after;

    // Reserved op passes the operand through untouched, so it never shifts.
    always_comb begin
        accept_rem = cmd_amt;
        if (cmd_op == 2'b11) begin
            accept_rem = 4'd0;
        end
`ifdef SHIFT_CTRL_SAT_EN
        else if (cmd_op == 2'b10) begin
            if (cmd_amt > 4'd7) accept_rem = 4'd7;
        end else begin
            if (cmd_amt > 4'd8) accept_rem = 4'd8;
        end
`endif
    end

    assign step      = (rem_reg >= 4'd3) ? 2'd3 : rem_reg[1:0];
    assign rem_after = rem_reg - {2'b00, step};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            op_reg    <= 2'b00;
            rem_reg   <= 4'd0;
            data_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            rem_reg   <= rem_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        rem_next   = rem_reg;
        data_next  = data_reg;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        res_data   = 8'h00;
        busy       = 1'b1;
        sh_op      = SH_NOP;
        sh_shamt   = 2'd0;
        sh_d_in    = 8'h00;

        unique case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_next    = cmd_op;
                    data_next  = cmd_data;
                    rem_next   = accept_rem;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_op      = SH_LOAD;
                sh_d_in    = data_reg;
                state_next = (rem_reg != 4'd0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                sh_shamt = step;
                case (op_reg)
                    2'b00:   sh_op = SH_LSL;
                    2'b01:   sh_op = SH_LSR;
                    2'b10:   sh_op = SH_ASR;
                    default: sh_op = SH_NOP;
                endcase
                rem_next = rem_after;
                if (rem_after == 4'd0) state_next = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                res_data  = sh_d_out;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_ctrl8.sv
// Randomized bench for shift_ctrl8 with a behavioural shifter8 and an arithmetic reference model.
module tb_shift_ctrl8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_amt;
    logic [7:0] cmd_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
    logic [2:0] sh_op;
    logic [1:0] sh_shamt;
    logic [7:0] sh_d_in;
    logic [7:0] sh_d_out;
    logic [7:0] sh_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_ctrl8 dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .sh_op(sh_op), .sh_shamt(sh_shamt),
        .sh_d_in(sh_d_in), .sh_d_out(sh_d_out)
    );

    // Behavioural shifter8: registered output updating on the edge that samples op.
    assign sh_d_out = sh_q;
    always @(posedge clk) begin
        case (sh_op)
            3'b001:  sh_q <= sh_d_in;
            3'b010:  sh_q <= sh_q << sh_shamt;
            3'b011:  sh_q <= sh_q >> sh_shamt;
            3'b100:  sh_q <= $signed(sh_q) >>> sh_shamt;
            default: sh_q <= sh_q;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_result(input int op, input int amt, input int data);
        int s;
        case (op)
            0: return (data * (1 << amt)) & 255;
            1: return data >> amt;
            2: begin
                s = (data >= 128) ? data - 256 : data;
                return (s >>> amt) & 255;
            end
            default: return data;
        endcase
    endfunction

    function automatic int eff_rem(input int op, input int amt);
        if (op == 3) return 0;
`ifdef SHIFT_CTRL_SAT_EN
        if (op == 2) return (amt > 7) ? 7 : amt;
        return (amt > 8) ? 8 : amt;
`else
        return amt;
`endif
    endfunction

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic run_cmd(input int op, input int amt, input int data, input int hold);
        int steps[$];
        int r, j, k, exp;
        r = eff_rem(op, amt);
        while (r > 0) begin
            steps.push_back((r > 3) ? 3 : r);
            r -= (r > 3) ? 3 : r;
        end
        k   = steps.size();
        exp = ref_result(op, amt, data);

        check_val("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_amt   = 4'(amt);
        cmd_data  = 8'(data);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_amt   = 4'($urandom);
        cmd_data  = 8'($urandom);

        j = 0;
        while (!res_valid && j < 20) begin
            if (j == 0) begin
                check_val("load_op", sh_op, 3'b001);
                check_val("load_d_in", sh_d_in, data);
                check_val("busy_cmd_ready", {busy, cmd_ready}, 2'b10);
            end else if (j <= k) begin
                check_val("shift_op", sh_op, 2 + op);
                check_val("shift_amt", sh_shamt, steps[j-1]);
            end
            @(negedge clk);
            j++;
        end
        check_val("latency", j, 1 + k);
        $display("cmd op=%0d amt=%0d data=0x%02h -> res=0x%02h exp=0x%02h edges=%0d hold=%0d",
                 op, amt, data, res_data, exp, j, hold);
        if (!res_valid) return;
        check_val("res_data", res_data, exp);
        check_val("done_sh_idle", {sh_op, sh_shamt, sh_d_in}, 0);

        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
                cmd_amt   = 4'($urandom);
                cmd_data  = 8'($urandom);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            check_val("hold_valid", res_valid, 1);
            check_val("hold_data", res_data, exp);
            check_val("hold_cmd_ready", cmd_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("back_idle", {res_valid, cmd_ready, busy}, 3'b010);
        check_val("idle_res_data", res_data, 0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_amt   = 4'd0;
        cmd_data  = 8'h00;
        res_ready = 1'b0;
        @(negedge clk);
        check_val("rst_ready_valid_busy", {cmd_ready, res_valid, busy}, 3'b100);
        check_val("rst_sh", {sh_op, sh_shamt, sh_d_in}, 0);
        check_val("rst_res_data", res_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(0, 2, 8'hAC, 0);
        run_cmd(2, 7, 8'hAC, 0);
        run_cmd(1, 12, 8'hAC, 0);
        run_cmd(0, 0, 8'h5A, 0);
        run_cmd(3, 5, 8'h5A, 0);
        run_cmd(0, 3, 8'h81, 5);
        run_cmd(2, 15, 8'h80, 0);
        run_cmd(0, 8, 8'hFF, 1);

        // Abort an LSL 9 while it is shifting.
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_amt   = 4'd9;
        cmd_data  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_val("abort_in_shift", sh_op, 3'b010);
        #2 reset = 1'b1;
        #1;
        check_val("abort_flags", {busy, res_valid, cmd_ready}, 3'b001);
        check_val("abort_sh", {sh_op, sh_shamt, sh_d_in}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_cmd(0, 9, 8'h3C, 0);

        for (int t = 0; t < 40; t++) begin
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
